// File: rtl/user_uart_rx_pkg.sv
// Shared definitions for the UART receive peripheral: register word offsets,
// the empty-read marker and the receive FSM states.
package user_uart_rx_pkg;

  localparam int unsigned UART_RX_DATA  = 0;
  localparam int unsigned UART_RX_STAT  = 1;
  localparam logic [31:0] UART_RX_EMPTY = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant SoC bus shared by the user peripherals.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  input  rd_gnt, rd_data, wr_gnt);
  modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/user_uart_rx_fifo.sv
// Byte FIFO for received characters; register array with a combinational head.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module user_uart_rx_fifo #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [FIFO_AW:0] len_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q;
  logic          pop_ok;
  logic          push_ok;

  assign len_o   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (len_o == LW'(DEPTH));
  assign empty_o = (len_o == '0);
  assign head_o  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/user_uart_rx.sv
// UART 8N1 receiver slave on naive_bus with pop-on-read data and status registers.
// Define UART_RX_FRAME_ERR_EN to drop bytes with a low stop bit and flag frame_err.
module user_uart_rx
  import user_uart_rx_pkg::*;
#(
  parameter int unsigned UART_RX_CLK_DIV = 434,
  parameter int unsigned FIFO_AW         = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_uart_rx,
  output logic     o_irq,
  naive_bus.slave  bus
);

  localparam int unsigned CNT_W = $clog2(UART_RX_CLK_DIV);
  localparam int unsigned LW    = FIFO_AW + 1;

  logic             rx_s1_q, rx_sync_q, rx_prev_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             cnt_last, cnt_half;
  logic             push_c, pop_c, push_acc_c;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [LW-1:0]    fifo_len, len_nxt;
  logic [29:0]      rd_word;
  logic             wr_stat;
  logic             overflow_q, overflow_d;
  logic             frame_err_c;
  logic             irq_q, irq_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             unused_bus_c;

  assign cnt_last = (cnt_q == CNT_W'(UART_RX_CLK_DIV - 1));
  assign cnt_half = (cnt_q == CNT_W'(UART_RX_CLK_DIV / 2 - 1));

  // Synchroniser, edge detector and frame FSM; cnt restarts on each state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_s1_q   <= i_uart_rx;
      rx_sync_q <= rx_s1_q;
      rx_prev_q <= rx_sync_q;
      cnt_q     <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q & ~rx_sync_q) state_q <= START;
        end
        START: begin
          if (cnt_half) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_sync_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_stat = bus.wr_req & bus.wr_be[0] & (bus.wr_addr[31:2] == 30'(UART_RX_STAT));

`ifdef UART_RX_FRAME_ERR_EN
  logic frame_err_q;
  assign push_c      = (state_q == STOP) & cnt_last & rx_sync_q;
  assign frame_err_c = frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= ((state_q == STOP) & cnt_last & ~rx_sync_q)
                          | (frame_err_q & ~(wr_stat & bus.wr_data[1]));
  end
`else
  assign push_c      = (state_q == STOP) & cnt_last;
  assign frame_err_c = 1'b0;
`endif

  user_uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (shift_q),
    .pop_i   (pop_c),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .len_o   (fifo_len)
  );

  assign rd_word    = bus.rd_addr[31:2];
  assign pop_c      = bus.rd_req & (rd_word == 30'(UART_RX_DATA)) & ~fifo_empty;
  assign push_acc_c = push_c & (~fifo_full | pop_c);
  assign len_nxt    = fifo_len + LW'(push_acc_c) - LW'(pop_c);

  // Next values for flags, irq and read data.
  always_comb begin
    overflow_d = (push_c & fifo_full & ~pop_c) | (overflow_q & ~(wr_stat & bus.wr_data[0]));
    irq_d      = (len_nxt != '0);
    rd_data_d  = '0;
    if (bus.rd_req) begin
      if (rd_word == 30'(UART_RX_DATA))
        rd_data_d = fifo_empty ? UART_RX_EMPTY : {24'h0, fifo_head};
      else if (rd_word == 30'(UART_RX_STAT))
        rd_data_d = {16'(fifo_len), 14'h0, frame_err_c, overflow_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_irq       = irq_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_gnt  = bus.rd_req;
  assign bus.wr_gnt  = bus.wr_req;

  assign unused_bus_c = ^{bus.rd_addr[1:0], bus.wr_addr[1:0], bus.wr_data[31:1], bus.wr_be[3:1]};

endmodule

// File: tb/tb_user_uart_rx.sv
// Self-checking bench for user_uart_rx at UART_RX_CLK_DIV=8, FIFO_AW=4.
module tb_user_uart_rx;

  localparam int unsigned DIV = 8;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic irq;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  naive_bus bus_if ();

  user_uart_rx #(.UART_RX_CLK_DIV(DIV), .FIFO_AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_uart_rx (rx),
    .o_irq     (irq),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = addr;
    #1;
    check("rd_gnt", 32'(bus_if.rd_gnt), 32'h1);
    @(posedge clk);
    #1;
    bus_if.rd_req  = 1'b0;
    bus_if.rd_addr = '0;
    d = bus_if.rd_data;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = addr;
    bus_if.wr_data = data;
    bus_if.wr_be   = 4'hF;
    cycles(1);
    bus_if.wr_req  = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    cycles(DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
    cycles(2 * DIV);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    rx  = 1'b1;
    bus_if.rd_req = 1'b0; bus_if.rd_addr = '0;
    bus_if.wr_req = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0; bus_if.wr_be = '0;
    cycles(3);
    check("rst_rd_data", bus_if.rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    cycles(4);

    bus_read(32'h4, d);   check("init_status", d, 32'h0);
    bus_read(32'h0, d);   check("empty_read", d, 32'h8000_0000);
    cycles(1);            check("rd_data_idle", bus_if.rd_data, 32'h0);
    bus_read(32'h4, d);   check("empty_len", d, 32'h0);
    bus_read(32'h8, d);   check("other_addr", d, 32'h0);

    check("irq_before", 32'(irq), 32'h0);
    send_byte(8'hA5, 1'b1);
    check("irq_high", 32'(irq), 32'h1);
    bus_read(32'h0, d);   check("data_a5", d, 32'h0000_00A5);
    check("irq_low", 32'(irq), 32'h0);
    bus_read(32'h4, d);   check("len_after_a5", d, 32'h0);

    // Short low pulse must be rejected as a glitch.
    rx = 1'b0; cycles(2); rx = 1'b1; cycles(20);
    bus_read(32'h4, d);   check("glitch_len", d, 32'h0);
    send_byte(8'h81, 1'b1);
    bus_read(32'h0, d);   check("post_glitch", d, 32'h0000_0081);

    send_byte(8'h3C, 1'b0);
`ifdef UART_RX_FRAME_ERR_EN
    bus_read(32'h4, d);   check("ferr_status", d, 32'h0000_0002);
    bus_write(32'h4, 32'h2);
    bus_read(32'h4, d);   check("ferr_clear", d, 32'h0);
`else
    bus_read(32'h4, d);   check("nferr_status", d, 32'h0001_0000);
    bus_read(32'h0, d);   check("nferr_data", d, 32'h0000_003C);
    bus_write(32'h4, 32'h2);
    bus_read(32'h4, d);   check("nferr_clear", d, 32'h0);
`endif

    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    vecs.push_back('{1'b0, 32'h4, 32'h0, 32'h0010_0001});
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b0, 32'h0, 32'h0, 32'(i)});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 32'h8000_0000});
    vecs.push_back('{1'b0, 32'h4, 32'h0, 32'h0000_0001});
    vecs.push_back('{1'b1, 32'h4, 32'h1, 32'h0});
    vecs.push_back('{1'b0, 32'h4, 32'h0, 32'h0});
    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // Reset in the middle of a frame with an entry already queued.
    send_byte(8'h11, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rx = 1'b0;
    cycles(DIV / 2);
    rst = 1'b1;
    #3;
    check("midrst_rd_data", bus_if.rd_data, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    rx = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2 * DIV);
    send_byte(8'h5A, 1'b1);
    bus_read(32'h4, d);   check("rst_len", d, 32'h0001_0000);
    bus_read(32'h0, d);   check("rst_data", d, 32'h0000_005A);
    bus_read(32'h0, d);   check("rst_empty", d, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
